// File: rtl/l1_mem_pkg.sv
// Shared definitions for the L1 memory subsystem: default widths, arbiter
// FSM encoding and client identifiers (also used by the cache blocks).
package l1_mem_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    CLI_I = 1'b0,
    CLI_D = 1'b1
  } client_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-requester round-robin selector: on a tie, the client
// that was not granted last wins.
module rr_pick2
  import l1_mem_pkg::*;
(
  input  logic    req_i,
  input  logic    req_d,
  input  client_e last,
  output logic    grant_valid,
  output client_e grant_id
);

  always_comb begin
    grant_valid = req_i | req_d;
    if (req_i && req_d) begin
      grant_id = (last == CLI_D) ? CLI_I : CLI_D;
    end else if (req_i) begin
      grant_id = CLI_I;
    end else begin
      grant_id = CLI_D;
    end
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Arbiter between the L1 I-cache and D-cache for the single memory port, with
// registered memory-side request and saturating per-client completion counters.
module l1_mem_arbiter
  import l1_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  i_count,
  output logic [CNT_W-1:0]  d_count
);

  arb_state_e        state_q, state_d;
  client_e           grant_q, grant_d;
  client_e           last_q, last_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  i_cnt_q, i_cnt_d;
  logic [CNT_W-1:0]  d_cnt_q, d_cnt_d;

  logic    pick_valid;
  client_e pick_id;

  rr_pick2 u_pick (
    .req_i       (i_read | i_write),
    .req_d       (d_read | d_write),
    .last        (last_q),
    .grant_valid (pick_valid),
    .grant_id    (pick_id)
  );

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path
    // through the case leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_cnt_d     = i_cnt_q;
    d_cnt_d     = d_cnt_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          grant_d = pick_id;
          // Write dominates an illegal read+write so the strobes stay exclusive.
          if (pick_id == CLI_I) begin
            mem_write_d = i_write;
            mem_read_d  = ~i_write;
            mem_addr_d  = i_addr;
            mem_wdata_d = i_wdata;
          end else begin
            mem_write_d = d_write;
            mem_read_d  = ~d_write;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          last_d      = grant_q;
          if (grant_q == CLI_I) begin
            if (~&i_cnt_q) i_cnt_d = i_cnt_q + CNT_W'(1);
          end else begin
            if (~&d_cnt_q) d_cnt_d = d_cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (!proc_reset_n) begin
      state_q     <= IDLE;
      grant_q     <= CLI_I;
      last_q      <= CLI_D;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_cnt_q     <= '0;
      d_cnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_cnt_q     <= i_cnt_d;
      d_cnt_q     <= d_cnt_d;
    end
  end

  assign i_ready   = (state_q == BUSY) && mem_ready && (grant_q == CLI_I);
  assign d_ready   = (state_q == BUSY) && mem_ready && (grant_q == CLI_D);
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_count   = i_cnt_q;
  assign d_count   = d_cnt_q;

endmodule
